mem_arbiter: RTL and testbench

- Shares the single 256x16 unified memory between the instruction-fetch requester (read-only) and the data requester (read/write) of the Von Neumann core.
- Sequences every memory access through a small FSM and drives the memory's enable, writeEnable, address and writeData inputs.
- Captures the memory's asynchronous read data into per-requester output registers.
- Arbitrates simultaneous requests round-robin, so neither requester starves.

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Requester and memory signals of the unified-memory arbiter.
// master: arbiter side; slave: requesters plus memory.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  fetchReq;
  logic [ADDR_WIDTH-1:0] fetchAddr;
  logic                  fetchReady;
  logic [DATA_WIDTH-1:0] fetchData;
  logic                  dataReq;
  logic                  dataWrite;
  logic [ADDR_WIDTH-1:0] dataAddr;
  logic [DATA_WIDTH-1:0] dataWData;
  logic                  dataReady;
  logic [DATA_WIDTH-1:0] dataRData;
  logic                  busy;
  logic                  memEnable;
  logic                  memWriteEnable;
  logic [ADDR_WIDTH-1:0] memAddress;
  logic [DATA_WIDTH-1:0] memWriteData;
  logic [DATA_WIDTH-1:0] memReadData;

  modport master (
    input  fetchReq, fetchAddr,
    input  dataReq, dataWrite, dataAddr, dataWData,
    input  memReadData,
    output fetchReady, fetchData,
    output dataReady, dataRData, busy,
    output memEnable, memWriteEnable,
    output memAddress, memWriteData
  );

  modport slave (
    output fetchReq, fetchAddr,
    output dataReq, dataWrite, dataAddr, dataWData,
    output memReadData,
    input  fetchReady, fetchData,
    input  dataReady, dataRData, busy,
    input  memEnable, memWriteEnable,
    input  memAddress, memWriteData
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one unified memory between the
// fetch and data requesters; one access cycle per grant.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter bit DATA_FIRST = 1'b1
) (
  input  logic           clock,
  input  logic           resetN,
  mem_arbiter_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DATA
  } state_e;

  state_e                state_q;
  logic                  rrLast_q;
  logic                  fReady_q;
  logic                  dReady_q;
  logic [DATA_WIDTH-1:0] fData_q;
  logic [DATA_WIDTH-1:0] rData_q;
  logic                  busy_q;
  logic                  en_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic fElig, dElig;
  logic pickD, pickF;

  // rrLast_q = 1 means data won the last grant
  always_comb begin
    fElig = bus.fetchReq & ~fReady_q;
    dElig = bus.dataReq & ~dReady_q;
    pickD = dElig & (~fElig | ~rrLast_q);
    pickF = fElig & ~pickD;
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      rrLast_q <= ~DATA_FIRST;
      fReady_q <= 1'b0;
      dReady_q <= 1'b0;
      fData_q  <= '0;
      rData_q  <= '0;
      busy_q   <= 1'b0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      fReady_q <= 1'b0;
      dReady_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pickD) begin
            state_q  <= DATA;
            rrLast_q <= 1'b1;
            busy_q   <= 1'b1;
            en_q     <= 1'b1;
            we_q     <= bus.dataWrite;
            addr_q   <= bus.dataAddr;
            wdata_q  <= bus.dataWData;
          end else if (pickF) begin
            state_q  <= FETCH;
            rrLast_q <= 1'b0;
            busy_q   <= 1'b1;
            en_q     <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= bus.fetchAddr;
            wdata_q  <= '0;
          end
        end
        FETCH: begin
          fData_q  <= bus.memReadData;
          fReady_q <= 1'b1;
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          en_q     <= 1'b0;
          we_q     <= 1'b0;
          addr_q   <= '0;
          wdata_q  <= '0;
        end
        DATA: begin
          if (!we_q) rData_q <= bus.memReadData;
          dReady_q <= 1'b1;
          state_q  <= IDLE;
          busy_q   <= 1'b0;
          en_q     <= 1'b0;
          we_q     <= 1'b0;
          addr_q   <= '0;
          wdata_q  <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.fetchReady     = fReady_q;
  assign bus.fetchData      = fData_q;
  assign bus.dataReady      = dReady_q;
  assign bus.dataRData      = rData_q;
  assign bus.busy           = busy_q;
  assign bus.memEnable      = en_q;
  assign bus.memWriteEnable = we_q;
  assign bus.memAddress     = addr_q;
  assign bus.memWriteData   = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level
// reference model, plus directed scenarios with literal checks.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DATA_FIRST(1'b1)
  ) dut (
    .clock (clk),
    .resetN(rst_n),
    .bus   (bus)
  );

  logic [DW-1:0] mem [256];
  logic          ld_en = 1'b0;
  logic [AW-1:0] ld_a = '0;
  logic [DW-1:0] ld_d = '0;

  assign bus.memReadData = mem[bus.memAddress];
  always @(posedge clk) begin
    if (ld_en) mem[ld_a] <= ld_d;
    else if (bus.memEnable && bus.memWriteEnable)
      mem[bus.memAddress] <= bus.memWriteData;
  end

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] ref_mem [256];
  bit            m_busy, m_who, m_wr, m_fr, m_dr, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wd, m_fd, m_rd;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_who = 0; m_wr = 0;
    m_fr = 0; m_dr = 0; m_last = 0;
    m_addr = '0; m_wd = '0; m_fd = '0; m_rd = '0;
  endtask

  // Effect of the clock edge just passed, using held inputs.
  task automatic model_step();
    bit ef, ed;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (m_busy) begin
      if (m_who) begin
        if (m_wr) ref_mem[m_addr] = m_wd;
        else m_rd = ref_mem[m_addr];
        m_dr = 1;
      end else begin
        m_fd = ref_mem[m_addr];
        m_fr = 1;
      end
      m_busy = 0;
    end else begin
      ef = bus.fetchReq && !m_fr;
      ed = bus.dataReq && !m_dr;
      m_fr = 0;
      m_dr = 0;
      if (ed && (!ef || !m_last)) begin
        m_busy = 1; m_who = 1; m_last = 1;
        m_addr = bus.dataAddr;
        m_wr = bus.dataWrite;
        m_wd = bus.dataWData;
      end else if (ef) begin
        m_busy = 1; m_who = 0; m_last = 0;
        m_addr = bus.fetchAddr;
        m_wr = 0;
        m_wd = '0;
      end
    end
  endtask

  task automatic compare_all();
    chk("busy", bus.busy, m_busy);
    chk("memEnable", bus.memEnable, m_busy);
    chk("memWriteEnable", bus.memWriteEnable, m_busy && m_who && m_wr);
    chk("memAddress", bus.memAddress, m_busy ? m_addr : '0);
    chk("memWriteData", bus.memWriteData, (m_busy && m_who) ? m_wd : '0);
    chk("fetchReady", bus.fetchReady, m_fr);
    chk("dataReady", bus.dataReady, m_dr);
    chk("fetchData", bus.fetchData, m_fd);
    chk("dataRData", bus.dataRData, m_rd);
    chk("readyExclusive", bus.fetchReady && bus.dataReady, 0);
  endtask

  task automatic cyc();
    @(negedge clk);
    model_step();
    compare_all();
  endtask

  int n_we, n_rdy, n_en, bad;
  int last_t, rcnt;
  bit seq [$];

  initial begin
    bus.fetchReq = 0; bus.fetchAddr = '0;
    bus.dataReq = 0; bus.dataWrite = 0;
    bus.dataAddr = '0; bus.dataWData = '0;
    model_reset();

    // clear memory under reset, mem[5] = 0x1234
    for (int i = 0; i < 256; i++) begin
      ld_en = 1; ld_a = AW'(i);
      ld_d = (i == 5) ? 16'h1234 : 16'h0000;
      ref_mem[i] = ld_d;
      cyc();
    end
    ld_en = 0;
    cyc();
    rst_n = 1;

    // fetch of address 5
    bus.fetchReq = 1; bus.fetchAddr = 8'h05;
    cyc();
    chk("t1_en", bus.memEnable, 1);
    chk("t1_addr", bus.memAddress, 8'h05);
    chk("t1_we", bus.memWriteEnable, 0);
    cyc();
    chk("t1_ready", bus.fetchReady, 1);
    chk("t1_data", bus.fetchData, 16'h1234);
    bus.fetchReq = 0;
    cyc();
    chk("t1_pulse", bus.fetchReady, 0);

    // write 0xBEEF to 0xFF then read it back
    bus.dataReq = 1; bus.dataWrite = 1;
    bus.dataAddr = 8'hFF; bus.dataWData = 16'hBEEF;
    n_we = 0; n_rdy = 0;
    for (int i = 0; i < 12 && n_rdy < 2; i++) begin
      cyc();
      if (bus.memWriteEnable) n_we++;
      if (bus.dataReady) begin
        n_rdy++;
        bus.dataWrite = 0;
        bus.dataWData = 16'h0;
      end
    end
    bus.dataReq = 0;
    chk("t2_readies", n_rdy, 2);
    chk("t2_we_cycles", n_we, 1);
    chk("t2_rdata", bus.dataRData, 16'hBEEF);
    cyc();

    // both requesting from reset: D,F,D,F two cycles apart
    rst_n = 0;
    bus.fetchReq = 1; bus.fetchAddr = 8'h05;
    bus.dataReq = 1; bus.dataWrite = 0; bus.dataAddr = 8'hFF;
    cyc();
    chk("t3_rst_fdata", bus.fetchData, 0);
    chk("t3_rst_rdata", bus.dataRData, 0);
    rst_n = 1;
    seq.delete(); bad = 0; last_t = -1; rcnt = 0;
    for (int i = 0; i < 9; i++) begin
      cyc();
      if (bus.fetchReady || bus.dataReady) begin
        seq.push_back(bus.dataReady);
        if (last_t >= 0 && i - last_t != 2) bad++;
        last_t = i;
      end
    end
    bus.fetchReq = 0; bus.dataReq = 0;
    chk("t3_count", seq.size(), 4);
    if (seq.size() >= 4) begin
      rcnt = {28'd0, seq[0], seq[1], seq[2], seq[3]};
      chk("t3_order", rcnt, 4'b1010);
    end
    chk("t3_spacing", bad, 0);
    cyc(); cyc();

    // single requester held high: one access per handshake
    bus.fetchReq = 1; bus.fetchAddr = 8'h07;
    n_en = 0; n_rdy = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      if (bus.memEnable) n_en++;
      if (bus.fetchReady) n_rdy++;
      if (i == 11) bus.fetchReq = 0;
    end
    chk("t4_no_dup", n_en, n_rdy);
    chk("t4_progress", n_rdy >= 3, 1);

    // reset during a write to 0x10
    bus.dataReq = 1; bus.dataWrite = 1;
    bus.dataAddr = 8'h10; bus.dataWData = 16'hAAAA;
    cyc();
    chk("t5_we", bus.memWriteEnable, 1);
    rst_n = 0;
    #1;
    chk("t5_en_drop", bus.memEnable, 0);
    chk("t5_we_drop", bus.memWriteEnable, 0);
    chk("t5_busy", bus.busy, 0);
    chk("t5_addr", bus.memAddress, 0);
    model_reset();
    cyc();
    chk("t5_mem", mem[8'h10], 16'h0000);
    chk("t5_ready", bus.dataReady, 0);
    bus.dataReq = 0; bus.dataWrite = 0;
    rst_n = 1;
    cyc();

    // address change after grant is ignored
    bus.dataReq = 1; bus.dataAddr = 8'h20;
    cyc();
    chk("t6_addr0", bus.memAddress, 8'h20);
    bus.dataAddr = 8'h30;
    #1;
    chk("t6_addr1", bus.memAddress, 8'h20);
    cyc();
    bus.dataReq = 0;
    cyc();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (bus.fetchReady) bus.fetchReq = ($urandom_range(0, 1) == 1);
      else if (!bus.fetchReq) bus.fetchReq = ($urandom_range(0, 9) < 4);
      if (bus.fetchReady || !bus.fetchReq)
        bus.fetchAddr = ($urandom_range(0, 7) == 0) ? AW'($urandom) :
                        AW'($urandom_range(0, 15));
      if (bus.dataReady) bus.dataReq = ($urandom_range(0, 1) == 1);
      else if (!bus.dataReq) bus.dataReq = ($urandom_range(0, 9) < 4);
      if (bus.dataReady || !bus.dataReq) begin
        bus.dataWrite = $urandom_range(0, 1) == 1;
        bus.dataAddr = ($urandom_range(0, 7) == 0) ? AW'($urandom) :
                       AW'($urandom_range(0, 15));
        bus.dataWData = DW'($urandom);
      end
    end
    bus.fetchReq = 0; bus.dataReq = 0;
    cyc(); cyc(); cyc();

    bad = 0;
    for (int i = 0; i < 256; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
